lc3b_exec_seq: RTL and testbench

Operand sequencer and register file that drives the LC-3b ALU and consumes its result. It holds the eight 16-bit general registers, fetches source operands for an operate instruction, presents them with the function code to the ALU, captures the ALU's registered result, writes it back and updates the NZP condition codes. It is the issuing and writeback end of the ALU A/B/ALUK/OUT interface.

---
 rtl/lc3b_exec_seq.sv | 160 ++++++++++++++++
 tb/tb_lc3b_exec_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_exec_seq.sv
// LC-3b operand sequencer and register file: issues operands to the external ALU,
// then writes the ALU's registered result back and updates the NZP condition codes.
module lc3b_exec_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [2:0]        dr,
    input  logic [2:0]        sr1,
    input  logic [2:0]        sr2,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] imm,
    input  logic              ld_en,
    input  logic [2:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        aluk,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy,
    output logic              done,
    output logic              n,
    output logic              z,
    output logic              p
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   regs_r [8];
    logic [1:0]          op_r;
    logic [2:0]          dr_r;
    logic [2:0]          sr1_r;
    logic [2:0]          sr2_r;
    logic                imm_sel_r;
    logic [DATA_W-1:0]   imm_r;
    logic [DATA_W-1:0]   alu_a_r;
    logic [DATA_W-1:0]   alu_b_r;
    logic [1:0]          aluk_r;
    logic                busy_r;
    logic                done_r;
    logic                n_r;
    logic                z_r;
    logic                p_r;
    logic [DATA_W-1:0]   b_sel_s;
    logic                res_zero_s;
    logic                res_neg_s;

    // Next-state logic for the fixed IDLE/READ/EXEC/WB cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_READ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ:  state_s = S_EXEC;
            S_EXEC:  state_s = S_WB;
            S_WB:    state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Operand B selection and result classification for the condition codes.
    always_comb begin
        b_sel_s    = {DATA_W{1'b0}};
        res_zero_s = (alu_out == {DATA_W{1'b0}});
        res_neg_s  = alu_out[DATA_W-1];
        if (imm_sel_r) begin
            b_sel_s = imm_r;
        end else begin
            b_sel_s = regs_r[sr2_r];
        end
    end

    // Sequencer state, latched instruction fields, ALU operands and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            op_r      <= 2'd0;
            dr_r      <= 3'd0;
            sr1_r     <= 3'd0;
            sr2_r     <= 3'd0;
            imm_sel_r <= 1'b0;
            imm_r     <= {DATA_W{1'b0}};
            alu_a_r   <= {DATA_W{1'b0}};
            alu_b_r   <= {DATA_W{1'b0}};
            aluk_r    <= 2'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            n_r       <= 1'b0;
            z_r       <= 1'b1;
            p_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != S_IDLE);
            done_r  <= (state_r == S_WB);
            if (state_r == S_IDLE && start) begin
                op_r      <= op;
                dr_r      <= dr;
                sr1_r     <= sr1;
                sr2_r     <= sr2;
                imm_sel_r <= imm_sel;
                imm_r     <= imm;
            end
            // Register reads see pre-edge contents, so a same-edge load is not observed here.
            if (state_r == S_READ) begin
                alu_a_r <= regs_r[sr1_r];
                alu_b_r <= b_sel_s;
                aluk_r  <= op_r;
            end
            if (state_r == S_WB) begin
                n_r <= res_neg_s;
                z_r <= res_zero_s;
                p_r <= ~res_neg_s & ~res_zero_s;
            end
        end
    end

    // Register file: writeback takes priority over the external load port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (state_r == S_WB && dr_r == 3'(i)) begin
                    regs_r[i] <= alu_out;
                end else if (ld_en && ld_addr == 3'(i)) begin
                    regs_r[i] <= ld_data;
                end
            end
        end
    end

    assign rd_data = regs_r[rd_addr];
    assign alu_a   = alu_a_r;
    assign alu_b   = alu_b_r;
    assign aluk    = aluk_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign n       = n_r;
    assign z       = z_r;
    assign p       = p_r;

endmodule

// File: tb/tb_lc3b_exec_seq.sv
// Self-checking bench for lc3b_exec_seq with a registered ALU model and a result scoreboard.
module tb_lc3b_exec_seq;

    localparam int DATA_W = 16;
    localparam int M_NONE    = 0;
    localparam int M_LD_READ = 1;
    localparam int M_LD_WB   = 2;
    localparam int M_START   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        op = 2'd0;
    logic [2:0]        dr = 3'd0;
    logic [2:0]        sr1 = 3'd0;
    logic [2:0]        sr2 = 3'd0;
    logic              imm_sel = 1'b0;
    logic [DATA_W-1:0] imm = 16'h0000;
    logic              ld_en = 1'b0;
    logic [2:0]        ld_addr = 3'd0;
    logic [DATA_W-1:0] ld_data = 16'h0000;
    logic [2:0]        rd_addr = 3'd0;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        aluk;
    logic [DATA_W-1:0] alu_out;
    logic              busy;
    logic              done;
    logic              n;
    logic              z;
    logic              p;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [2:0]  dr;
        logic [15:0] res;
        logic [2:0]  nzp;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        imm_sel;
        logic [15:0] imm;
        logic [15:0] res;
        logic [2:0]  nzp;
    } vec_t;
    vec_t vecs[6];

    lc3b_exec_seq #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .dr(dr), .sr1(sr1), .sr2(sr2),
        .imm_sel(imm_sel), .imm(imm), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .alu_a(alu_a), .alu_b(alu_b), .aluk(aluk),
        .alu_out(alu_out), .busy(busy), .done(done), .n(n), .z(z), .p(p)
    );

    always #5 clk = ~clk;

    // Registered ALU model sampling the operands the sequencer presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out <= 16'h0000;
        end else begin
            case (aluk)
                2'd0:    alu_out <= alu_a + alu_b;
                2'd1:    alu_out <= alu_a & alu_b;
                2'd2:    alu_out <= alu_a ^ alu_b;
                default: alu_out <= alu_a;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] v);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
        rd_addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [2:0] d,
                          input logic [2:0] s1, input logic [2:0] s2, input logic is,
                          input logic [15:0] im, input logic [15:0] res, input logic [2:0] nzp,
                          input int mode, input logic [2:0] la, input logic [15:0] lv,
                          output logic [15:0] a_cap, output logic [15:0] b_cap);
        exp_t e;
        int cyc;
        int busyc;
        e.name = name; e.dr = d; e.res = res; e.nzp = nzp;
        exp_q.push_back(e);
        op = o; dr = d; sr1 = s1; sr2 = s2; imm_sel = is; imm = im; rd_addr = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble fields after acceptance; the latched copies must be used.
        op = ~o; dr = ~d; sr1 = ~s1; sr2 = ~s2; imm_sel = ~is; imm = ~im;
        cyc = 1;
        busyc = busy ? 1 : 0;
        a_cap = 16'h0000; b_cap = 16'h0000;
        while (!done && cyc < 12) begin
            if (mode == M_LD_READ && cyc == 1) begin
                ld_en = 1'b1; ld_addr = la; ld_data = lv;
            end
            if (mode == M_LD_WB && cyc == 3) begin
                ld_en = 1'b1; ld_addr = la; ld_data = lv;
            end
            if (mode == M_START && cyc == 2) begin
                start = 1'b1;
            end
            tick();
            cyc++;
            ld_en = 1'b0;
            start = 1'b0;
            if (cyc == 2) begin
                a_cap = alu_a; b_cap = alu_b;
            end
            if (busy) busyc++;
        end
        e = exp_q.pop_front();
        if (done) begin
            check({e.name, "_result"}, {16'h0, rd_data}, {16'h0, e.res});
            check({e.name, "_nzp"}, {29'h0, n, z, p}, {29'h0, e.nzp});
            check({e.name, "_latency"}, cyc, 4);
            check({e.name, "_busy_cycles"}, busyc, 3);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", e.name);
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] a_cap;
        logic [15:0] b_cap;
        int dones;

        vecs[0] = '{"add",      2'd0, 16'h0005, 16'h0003, 1'b0, 16'h0000, 16'h0008, 3'b001};
        vecs[1] = '{"add_wrap", 2'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 3'b010};
        vecs[2] = '{"and",      2'd1, 16'hF0F0, 16'h0FF0, 1'b0, 16'h0000, 16'h00F0, 3'b001};
        vecs[3] = '{"pass",     2'd3, 16'h8000, 16'h1234, 1'b0, 16'h0000, 16'h8000, 3'b100};
        vecs[4] = '{"xor",      2'd2, 16'hA5A5, 16'hFFFF, 1'b0, 16'h0000, 16'h5A5A, 3'b001};
        vecs[5] = '{"add_imm",  2'd0, 16'h7FFF, 16'h4444, 1'b1, 16'h0001, 16'h8000, 3'b100};

        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            check($sformatf("reset_r%0d", i), {16'h0, v}, 32'h0);
        end
        check("reset_nzp", {29'h0, n, z, p}, 32'h2);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_alu_a", {16'h0, alu_a}, 32'h0);
        check("reset_alu_b", {16'h0, alu_b}, 32'h0);
        check("reset_aluk", {30'h0, aluk}, 32'h0);

        // Table of operate instructions: R3 <= R1 op (R2 | imm)
        for (int i = 0; i < 6; i++) begin
            load(3'd1, vecs[i].a);
            load(3'd2, vecs[i].b);
            run_op(vecs[i].name, vecs[i].op, 3'd3, 3'd1, 3'd2, vecs[i].imm_sel, vecs[i].imm,
                   vecs[i].res, vecs[i].nzp, M_NONE, 3'd0, 16'h0, a_cap, b_cap);
            check({vecs[i].name, "_alu_a"}, {16'h0, a_cap}, {16'h0, vecs[i].a});
            check({vecs[i].name, "_alu_b"}, {16'h0, b_cap},
                  {16'h0, vecs[i].imm_sel ? vecs[i].imm : vecs[i].b});
        end

        // Immediate sign then XOR of a register with itself into itself
        load(3'd1, 16'h0001);
        run_op("imm_neg", 2'd0, 3'd1, 3'd1, 3'd0, 1'b1, 16'hFFFE, 16'hFFFF, 3'b100,
               M_NONE, 3'd0, 16'h0, a_cap, b_cap);
        run_op("xor_self", 2'd2, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0000, 16'h0000, 3'b010,
               M_NONE, 3'd0, 16'h0, a_cap, b_cap);

        // A load leaves NZP untouched
        load(3'd6, 16'h8001);
        check("load_keeps_nzp", {29'h0, n, z, p}, 32'h2);
        read_reg(3'd6, v);
        check("load_r6", {16'h0, v}, 32'h8001);

        // Load to dr on the writeback edge loses to the ALU result
        load(3'd1, 16'h0010);
        load(3'd2, 16'h0020);
        run_op("ld_wb_same", 2'd0, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0030, 3'b001,
               M_LD_WB, 3'd4, 16'hDEAD, a_cap, b_cap);

        // Load to a different register on the writeback edge: both writes land
        run_op("ld_wb_diff", 2'd1, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0000, 3'b010,
               M_LD_WB, 3'd5, 16'h1357, a_cap, b_cap);
        read_reg(3'd5, v);
        check("ld_wb_diff_r5", {16'h0, v}, 32'h1357);

        // Load to sr1 on the READ edge is not seen by the operation
        load(3'd1, 16'h0010);
        load(3'd2, 16'h0001);
        run_op("ld_read_sr1", 2'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0011, 3'b001,
               M_LD_READ, 3'd1, 16'h0100, a_cap, b_cap);
        check("ld_read_alu_a_old", {16'h0, a_cap}, 32'h0010);
        read_reg(3'd1, v);
        check("ld_read_r1_new", {16'h0, v}, 32'h0100);

        // start pulsed while busy is ignored
        run_op("start_busy", 2'd2, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0101, 3'b001,
               M_START, 3'd0, 16'h0, a_cap, b_cap);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dones++;
        end
        check("start_busy_extra_done", dones, 0);
        check("start_busy_idle", {31'h0, busy}, 32'h0);

        // Reset during EXEC aborts the operation and clears registers
        load(3'd1, 16'h0002);
        load(3'd2, 16'h0003);
        op = 2'd0; dr = 3'd4; sr1 = 3'd1; sr2 = 3'd2; imm_sel = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            tick();
        end
        check("rst_exec_no_done", dones, 0);
        check("rst_exec_busy", {31'h0, busy}, 32'h0);
        read_reg(3'd4, v);
        check("rst_exec_r4", {16'h0, v}, 32'h0);
        read_reg(3'd1, v);
        check("rst_exec_r1", {16'h0, v}, 32'h0);
        check("rst_exec_nzp", {29'h0, n, z, p}, 32'h2);
        load(3'd1, 16'h0007);
        load(3'd2, 16'h0001);
        run_op("after_rst", 2'd0, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0008, 3'b001,
               M_NONE, 3'd0, 16'h0, a_cap, b_cap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
